fp_divider_seq: RTL
===================

Name: fp_divider_seq

Overview:
- Sequential IEEE-754 single-precision divider, y = a / b.
- Inverse operation to the team's combinational floating_multiplier, sitting beside it in the Jackfruit FP datapath.
- Restoring mantissa division, one quotient bit per clock, with a start/busy/done handshake.
- Truncation rounding and 8-bit wrapping exponent, matching the multiplier's numeric conventions.

Parameters:
- None. Single precision is fixed; widths and constants live in the package.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request; sampled only in IDLE
- a  input  32  dividend, IEEE-754 single
- b  input  32  divisor, IEEE-754 single
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  single-cycle pulse; y is valid from this cycle
- y  output  32  quotient, registered, held until the next result

Behaviour:
- Reset values (async, active-high): state=IDLE, busy=0, done=0, y=32'h0, counter=0, all datapath registers 0. Reset asserted mid-operation aborts the division; no done is produced.
- FSM states: IDLE, DIVIDE, NORM, DONE.
- IDLE: busy=0. When start=1 at a clock edge, latch the operands:
  - sign = a[31]^b[31]
  - m1 = {1,a[22:0]}, m2 = {1,b[22:0]}
  - rem = {2'b0,m1}, q = 0, cnt = 0
  - eraw = {2'b0,a[30:23]} - {2'b0,b[30:23]} + 127, 10-bit
  - next state DIVIDE.
- DIVIDE: busy=1. Each cycle:
  - if rem >= m2: q = {q[23:0],1}, rem = (rem-m2)<<1
  - else: q = {q[23:0],0}, rem = rem<<1
  - cnt increments; after 25 iterations (cnt==24 processed) go to NORM.
  - q is 25 bits: q[24] is the integer bit, q[23:0] the fraction bits.
- NORM: busy=1.
  - if q[24]=1: frac = q[23:1], exp = eraw[7:0]
  - else: frac = q[22:0], exp = eraw[7:0] - 1
  - y <= {sign, exp, frac}; next state DONE.
- DONE: busy=0, done=1 for exactly one cycle; next state IDLE.
- Latency: start sampled at edge E0; done high in the cycle following edge E0+26. Total 27 cycles start-to-done; back-to-back start is accepted in the cycle after done.
- start while busy (DIVIDE/NORM) or in DONE: ignored, no queueing. Operand changes while busy have no effect.
- Exponent overflow/underflow wraps modulo 256; no saturation.
- Rounding: truncation only.
- Denormal inputs are treated as normals (hidden bit forced to 1).

Optional Feature:
- Macro: FP_DIV_SPECIAL_EN.
- Defined, evaluated in NORM (same latency):
  - b[30:23]==0 and a[30:23]!=0: y = {sign, 8'hFF, 23'h0} (infinity)
  - a[30:23]==0: y = {sign, 31'h0}, including 0/0
  - a or b exponent 8'hFF: y = {1'b0, 8'hFF, 23'h400000} (quiet NaN)
- Not defined: no special-case logic; the raw datapath result is emitted.

Decomposition:
- Package fp_div_pkg:
  - state_t enum {IDLE, DIVIDE, NORM, DONE}
  - localparams EXP_W=8, FRAC_W=23, MANT_W=24, BIAS=127, ITERS=25
  - QNAN=32'h7FC00000, INF_EXP=8'hFF
- Sub-module fp_mant_divider: iterative restoring core.
  - Inputs: clk, reset, load, m1, m2.
  - Outputs: q[24:0], last.
  - Top level keeps the FSM, sign/exponent path and packing.

Test Plan:
- a=40C00000 (6.0), b=40000000 (2.0), start pulse -> y=40400000, done exactly 27 cycles after start, busy high 26 cycles.
- a=3F800000 (1.0), b=3FC00000 (1.5) -> q[24]=0 path, y=3F2AAAAA (truncated 0.6667).
- a=3F800000, b=40400000 (3.0) -> y=3EAAAAAA; a=C0F00000 (-7.5), b=40200000 (2.5) -> y=C0400000.
- start re-pulsed at cycles 5 and 20 of an operation -> ignored, single done, result unchanged; reset asserted at cycle 10 -> busy=0, done never pulses, y=0 asynchronously.
- With FP_DIV_SPECIAL_EN:
  - a=40A00000 (5.0), b=00000000 -> y=7F800000
  - a=00000000, b=40A00000 -> y=00000000
  - a=7F800000, b=3F800000 -> y=7FC00000
  - all with 27-cycle latency.
- Back-to-back: second start the cycle after done -> second result correct, no lost cycle.

Source files
------------

// File: rtl/fp_divider_seq_pkg.sv
// ---------------------------------------------------------------------------
// fp_div_pkg
// Shared widths, constants and state encoding for the sequential
// single-precision divider (fp_divider_seq) and its mantissa core.
// No ports; imported by the interface, the core and the top.
// ---------------------------------------------------------------------------
package fp_div_pkg;

  localparam int WORD_W = 32;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 24;
  localparam int BIAS   = 127;
  localparam int ITERS  = 25;
  localparam int CNT_W  = $clog2(ITERS);

  localparam logic [WORD_W-1:0] QNAN    = 32'h7FC00000;
  localparam logic [EXP_W-1:0]  INF_EXP = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    NORM   = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Biased exponent field of a single-precision word.
  function automatic logic [EXP_W-1:0] exp_field(input logic [WORD_W-1:0] w);
    return w[FRAC_W +: EXP_W];
  endfunction

  // Mantissa with the hidden bit forced to 1 (denormals treated as normals).
  function automatic logic [MANT_W-1:0] mant_field(input logic [WORD_W-1:0] w);
    return {1'b1, w[FRAC_W-1:0]};
  endfunction

endpackage

// File: rtl/fp_divider_seq_if.sv
// ---------------------------------------------------------------------------
// fp_divider_seq_if
// Request/response bundle of the sequential FP divider.
//   start  : request, sampled only while the divider is idle
//   a, b   : dividend / divisor, IEEE-754 single
//   busy   : division in progress
//   done   : one-cycle pulse, y valid from this cycle
//   y      : registered quotient, held until the next result
// master = requester side, slave = divider side.
// ---------------------------------------------------------------------------
interface fp_divider_seq_if;
  import fp_div_pkg::*;

  logic              start;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] y;

  modport master (output start, a, b, input busy, done, y);
  modport slave  (input start, a, b, output busy, done, y);

endinterface

// File: rtl/fp_divider_seq_mant_divider.sv
// ---------------------------------------------------------------------------
// fp_mant_divider
// Iterative restoring divider for 24-bit normalised mantissas, one quotient
// bit per clock, 25 quotient bits (1 integer + 24 fraction).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture m1/m2 and start iterating on the next cycle
//   m1, m2     : dividend / divisor mantissas (hidden bit included)
//   q          : quotient, q[24] integer bit; final once last has been seen
//   last       : high during the cycle whose iteration is the final one
// ---------------------------------------------------------------------------
module fp_mant_divider
  import fp_div_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [MANT_W-1:0] m1,
  input  logic [MANT_W-1:0] m2,
  output logic [ITERS-1:0]  q,
  output logic              last
);

  // Two headroom bits: the partial remainder stays below 2*m2 < 2^25
  // before the shift, so 26 bits never overflow.
  logic [MANT_W+1:0] rem;
  logic [MANT_W-1:0] dvsr;
  logic [CNT_W-1:0]  cnt;
  logic              running;

  logic [MANT_W+1:0] dvsr_ext;
  logic [MANT_W+1:0] diff;
  logic              ge;

  assign dvsr_ext = {2'b00, dvsr};
  assign diff     = rem - dvsr_ext;
  assign ge       = (rem >= dvsr_ext);
  assign last     = running && (cnt == CNT_W'(ITERS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem     <= '0;
      dvsr    <= '0;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (load) begin
      rem     <= {2'b00, m1};
      dvsr    <= m2;
      q       <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      // Restoring step: subtract only when it does not go negative.
      q   <= {q[ITERS-2:0], ge};
      rem <= (ge ? diff : rem) << 1;
      cnt <= cnt + CNT_W'(1);
      if (last) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fp_divider_seq.sv
// ---------------------------------------------------------------------------
// fp_divider_seq
// Sequential IEEE-754 single-precision divider, y = a / b. Restoring
// mantissa division at one bit per clock, truncation rounding and an 8-bit
// exponent that wraps modulo 256 (same numeric conventions as the
// combinational floating_multiplier). 27 cycles from start to done.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all state, aborts a division
//   io    : fp_divider_seq_if.slave (start, a, b in; busy, done, y out)
// Build option:
//   FP_DIV_SPECIAL_EN - when defined, zero / infinity / NaN operands are
//   detected in the normalise cycle and replace the raw datapath result.
//   When undefined, the raw datapath result is always emitted.
// ---------------------------------------------------------------------------
module fp_divider_seq
  import fp_div_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  fp_divider_seq_if.slave io
);

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_DIVIDE = DIVIDE;
  localparam logic [1:0] S_NORM   = NORM;
  localparam logic [1:0] S_DONE   = DONE;

  logic [1:0]        state;
  logic              sign;
  logic [EXP_W-1:0]  eraw;
  logic              busy_r;
  logic              done_r;
  logic [WORD_W-1:0] y_r;

  logic              load;
  logic              last;
  logic [ITERS-1:0]  q;

`ifdef FP_DIV_SPECIAL_EN
  logic [EXP_W-1:0]  ea;
  logic [EXP_W-1:0]  eb;
`endif

  assign load    = (state == S_IDLE) && io.start;
  assign io.busy = busy_r;
  assign io.done = done_r;
  assign io.y    = y_r;

  fp_mant_divider u_core (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .m1    (mant_field(io.a)),
    .m2    (mant_field(io.b)),
    .q     (q),
    .last  (last)
  );

  // Normalise by at most one place (quotient of two [1,2) mantissas lies in
  // (0.5, 2)) and truncate the surplus bit.
  function automatic logic [WORD_W-1:0] normalize(
    input logic             s,
    input logic [EXP_W-1:0] e,
    input logic [ITERS-1:0] qv
  );
    logic [EXP_W-1:0]  ex;
    logic [FRAC_W-1:0] fr;
    if (qv[ITERS-1]) begin
      fr = qv[ITERS-2:1];
      ex = e;
    end else begin
      fr = qv[ITERS-3:0];
      ex = e - EXP_W'(1);
    end
    return {s, ex, fr};
  endfunction

`ifdef FP_DIV_SPECIAL_EN
  // NaN wins over everything, then a zero dividend (covers 0/0), then a
  // zero divisor.
  function automatic logic [WORD_W-1:0] special_case(
    input logic              s,
    input logic [EXP_W-1:0]  ea_v,
    input logic [EXP_W-1:0]  eb_v,
    input logic [WORD_W-1:0] raw
  );
    if ((ea_v == INF_EXP) || (eb_v == INF_EXP)) begin
      return QNAN;
    end else if (ea_v == '0) begin
      return {s, {(WORD_W-1){1'b0}}};
    end else if (eb_v == '0) begin
      return {s, INF_EXP, {FRAC_W{1'b0}}};
    end else begin
      return raw;
    end
  endfunction
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      sign   <= 1'b0;
      eraw   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      y_r    <= '0;
`ifdef FP_DIV_SPECIAL_EN
      ea     <= '0;
      eb     <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (io.start) begin
            sign   <= io.a[WORD_W-1] ^ io.b[WORD_W-1];
            // Only the low 8 bits of the biased difference are ever used,
            // so it is formed directly modulo 256.
            eraw   <= exp_field(io.a) - exp_field(io.b) + EXP_W'(BIAS);
`ifdef FP_DIV_SPECIAL_EN
            ea     <= exp_field(io.a);
            eb     <= exp_field(io.b);
`endif
            busy_r <= 1'b1;
            state  <= S_DIVIDE;
          end
        end
        // ---- mantissa iterations run in the core ----
        S_DIVIDE: begin
          if (last) begin
            state <= S_NORM;
          end
        end
        // ---- normalise, pack, register the result ----
        S_NORM: begin
`ifdef FP_DIV_SPECIAL_EN
          y_r    <= special_case(sign, ea, eb, normalize(sign, eraw, q));
`else
          y_r    <= normalize(sign, eraw, q);
`endif
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
